// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the RV32I pipeline.
//   XLEN        : datapath / address width
//   RESET_ADDR  : PC value loaded at reset
//   NOP_INST    : addi x0,x0,0, the bubble placed into IF/ID on boot and flush
//   fetch_state_e : fetch FSM states (BOOT, RUN)
//   if_id_t     : contents of the IF/ID pipeline register
package rv_pipe_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_ADDR = 32'h0040_0000;
    localparam logic [XLEN-1:0] NOP_INST   = 32'h0000_0013;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcplus4;
        logic [XLEN-1:0] inst;
        logic            valid;
    } if_id_t;

endpackage

// File: rtl/perf_counter.sv
// Wrap-around performance counter.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   i_inc      : add one this cycle
//   i_clear    : zero the counter next edge; wins over a same-cycle i_inc
//   o_count    : current count, wraps modulo 2^CNT_W
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID register
// and fetch/stall/flush counters.
//   clk, rst_n          : clock, asynchronous active-low reset
//   PC_enable           : 0 = hold PC (hazard stall)
//   IF_ID_PCenable      : load enable for IF_ID_PC / IF_ID_PCplus4
//   IF_ID_INSTenable    : load enable for IF_ID_INST / IF_ID_valid
//   branch_taken/target : taken redirect resolved in ID
//   imem_addr/imem_rdata: instruction memory (asynchronous read)
//   IF_ID_*             : IF/ID pipeline register outputs
//   cnt_clear           : synchronous clear of all counters
//   fetch/stall/flush_cnt : performance counters
//   o_fsm_state         : debug view of the fetch FSM (0 = BOOT, 1 = RUN)
module if_fetch_stage
    import rv_pipe_pkg::*;
#(
    parameter int              CNT_W          = 32,
    parameter logic [XLEN-1:0] P_RESET_ADDR   = RESET_ADDR,
    parameter logic [XLEN-1:0] P_NOP_INST     = NOP_INST
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PC_enable,
    input  logic             IF_ID_PCenable,
    input  logic             IF_ID_INSTenable,
    input  logic             branch_taken,
    input  logic [XLEN-1:0]  branch_target,
    output logic [XLEN-1:0]  imem_addr,
    input  logic [XLEN-1:0]  imem_rdata,
    output logic [XLEN-1:0]  IF_ID_PC,
    output logic [XLEN-1:0]  IF_ID_PCplus4,
    output logic [XLEN-1:0]  IF_ID_INST,
    output logic             IF_ID_valid,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             o_fsm_state
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_pc_plus4;
    if_id_t          r_if_id;
    if_id_t          w_if_id_nxt;
    logic            w_fetch_inc;
    logic            w_stall_inc;
    logic            w_flush_inc;
    // Redirect targets are forced word-aligned, so the low bits are dropped.
    logic            w_unused_tgt_lo;

    assign w_unused_tgt_lo = ^branch_target[1:0];
    assign w_pc_plus4      = r_pc + XLEN'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= BOOT;
            r_pc            <= P_RESET_ADDR;
            r_if_id.pc      <= '0;
            r_if_id.pcplus4 <= '0;
            r_if_id.inst    <= P_NOP_INST;
            r_if_id.valid   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_if_id <= w_if_id_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_if_id_nxt = r_if_id;
        w_fetch_inc = 1'b0;
        w_stall_inc = 1'b0;
        w_flush_inc = 1'b0;

        case (r_state)
            BOOT: begin
                // One settling cycle: PC held, IF/ID primed with a bubble.
                w_if_id_nxt.inst  = P_NOP_INST;
                w_if_id_nxt.valid = 1'b0;
                w_state_nxt       = RUN;
            end
            RUN: begin
                // The PC side of IF/ID follows its own enable in every RUN case.
                if (IF_ID_PCenable) begin
                    w_if_id_nxt.pc      = r_pc;
                    w_if_id_nxt.pcplus4 = w_pc_plus4;
                end
                if (!PC_enable) begin
                    // Stall: branch_taken is not trusted during a hazard bubble.
                    w_stall_inc = 1'b1;
                    if (IF_ID_INSTenable) begin
                        w_if_id_nxt.inst  = imem_rdata;
                        w_if_id_nxt.valid = 1'b1;
                    end
                end else if (branch_taken) begin
                    // The instruction fetched this cycle is wrong-path: squash it.
                    w_pc_nxt          = {branch_target[XLEN-1:2], 2'b00};
                    w_if_id_nxt.inst  = P_NOP_INST;
                    w_if_id_nxt.valid = 1'b0;
                    w_flush_inc       = 1'b1;
                end else begin
                    w_pc_nxt = w_pc_plus4;
                    if (IF_ID_INSTenable) begin
                        w_if_id_nxt.inst  = imem_rdata;
                        w_if_id_nxt.valid = 1'b1;
                        w_fetch_inc       = 1'b1;
                    end
                end
            end
            default: w_state_nxt = BOOT;
        endcase
    end

    perf_counter #(.CNT_W(CNT_W)) u_fetch_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_fetch_inc),
        .i_clear (cnt_clear),
        .o_count (fetch_cnt)
    );

    perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_stall_inc),
        .i_clear (cnt_clear),
        .o_count (stall_cnt)
    );

    perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_flush_inc),
        .i_clear (cnt_clear),
        .o_count (flush_cnt)
    );

    assign imem_addr     = r_pc;
    assign IF_ID_PC      = r_if_id.pc;
    assign IF_ID_PCplus4 = r_if_id.pcplus4;
    assign IF_ID_INST    = r_if_id.inst;
    assign IF_ID_valid   = r_if_id.valid;
    assign o_fsm_state   = r_state;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table, hand sequences for
// counter wrap and mid-stall reset, then random traffic against a model.
// Counters are built 8 bits wide so the wrap case is reachable quickly.
module tb_if_fetch_stage;
    import rv_pipe_pkg::*;

    localparam int          CW      = 8;
    localparam logic [31:0] MEM_XOR = 32'hA5A5_0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pc_en, ifpc_en, ifinst_en, br;
    logic [31:0]   tgt;
    logic [31:0]   imem_addr, imem_rdata;
    logic [31:0]   if_pc, if_p4, if_inst;
    logic          if_v;
    logic          clr;
    logic [CW-1:0] f_cnt, s_cnt, fl_cnt;
    logic          dbg_state;

    int checks = 0;
    int errors = 0;

    if_fetch_stage #(.CNT_W(CW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .PC_enable        (pc_en),
        .IF_ID_PCenable   (ifpc_en),
        .IF_ID_INSTenable (ifinst_en),
        .branch_taken     (br),
        .branch_target    (tgt),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .IF_ID_PC         (if_pc),
        .IF_ID_PCplus4    (if_p4),
        .IF_ID_INST       (if_inst),
        .IF_ID_valid      (if_v),
        .cnt_clear        (clr),
        .fetch_cnt        (f_cnt),
        .stall_cnt        (s_cnt),
        .flush_cnt        (fl_cnt),
        .o_fsm_state      (dbg_state)
    );

    always #5 clk = ~clk;

    // Instruction memory: every word is its own address scrambled.
    assign imem_rdata = imem_addr ^ MEM_XOR;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic          m_boot;
    logic [31:0]   m_pc, m_ifpc, m_ifp4, m_inst;
    logic          m_v;
    logic [CW-1:0] m_f, m_s, m_fl;

    task automatic model_reset();
        m_boot = 1'b1; m_pc = 32'h0040_0000;
        m_ifpc = '0; m_ifp4 = '0; m_inst = 32'h13; m_v = 1'b0;
        m_f = '0; m_s = '0; m_fl = '0;
    endtask

    task automatic model_step();
        logic [31:0] word;
        word = m_pc ^ MEM_XOR;
        if (m_boot) begin
            m_boot = 1'b0; m_inst = 32'h13; m_v = 1'b0;
        end else begin
            if (ifpc_en) begin
                m_ifpc = m_pc; m_ifp4 = m_pc + 32'd4;
            end
            if (!pc_en) begin
                m_s = m_s + 1'b1;
                if (ifinst_en) begin m_inst = word; m_v = 1'b1; end
            end else if (br) begin
                m_pc = tgt & 32'hFFFF_FFFC;
                m_inst = 32'h13; m_v = 1'b0;
                m_fl = m_fl + 1'b1;
            end else begin
                m_pc = m_pc + 32'd4;
                if (ifinst_en) begin
                    m_inst = word; m_v = 1'b1; m_f = m_f + 1'b1;
                end
            end
        end
        if (clr) begin m_f = '0; m_s = '0; m_fl = '0; end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_addr"},  imem_addr, m_pc);
        chk({tag, "_ifpc"},  if_pc, m_ifpc);
        chk({tag, "_ifp4"},  if_p4, m_ifp4);
        chk({tag, "_inst"},  if_inst, m_inst);
        chk({tag, "_valid"}, 32'(if_v), 32'(m_v));
        chk({tag, "_fcnt"},  32'(f_cnt), 32'(m_f));
        chk({tag, "_scnt"},  32'(s_cnt), 32'(m_s));
        chk({tag, "_flcnt"}, 32'(fl_cnt), 32'(m_fl));
    endtask

    // Apply inputs for one cycle (called at posedge+1), return at next posedge+1.
    task automatic drive_cycle(input logic pe, input logic ppe, input logic ie,
                               input logic b, input logic [31:0] t, input logic c);
        pc_en = pe; ifpc_en = ppe; ifinst_en = ie; br = b; tgt = t; clr = c;
        model_step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic pe, ppe, ie, b;
        logic [31:0] t;
        logic c;
        logic [31:0] e_addr, e_pc, e_p4, e_inst;
        logic e_v;
        logic [CW-1:0] e_f, e_s, e_fl;
    } vec_t;

    function automatic vec_t mk(input logic pe, ppe, ie, b, input logic [31:0] t, input logic c,
                                input logic [31:0] ea, ep, e4, ei, input logic ev,
                                input logic [CW-1:0] ef, es, efl);
        vec_t v;
        v.pe = pe; v.ppe = ppe; v.ie = ie; v.b = b; v.t = t; v.c = c;
        v.e_addr = ea; v.e_pc = ep; v.e_p4 = e4; v.e_inst = ei; v.e_v = ev;
        v.e_f = ef; v.e_s = es; v.e_fl = efl;
        return v;
    endfunction

    vec_t vecs[16];

    initial begin
        // Row 0 is the BOOT cycle right after reset release.
        vecs[0]  = mk(1,1,1,0, 32'h0,        0, 32'h0040_0000, 32'h0,         32'h0,         32'h0000_0013, 0, 0, 0, 0);
        vecs[1]  = mk(1,1,1,0, 32'h0,        0, 32'h0040_0004, 32'h0040_0000, 32'h0040_0004, 32'hA5E5_0000, 1, 1, 0, 0);
        vecs[2]  = mk(1,1,1,0, 32'h0,        0, 32'h0040_0008, 32'h0040_0004, 32'h0040_0008, 32'hA5E5_0004, 1, 2, 0, 0);
        vecs[3]  = mk(1,1,1,0, 32'h0,        0, 32'h0040_000C, 32'h0040_0008, 32'h0040_000C, 32'hA5E5_0008, 1, 3, 0, 0);
        vecs[4]  = mk(1,1,1,0, 32'h0,        0, 32'h0040_0010, 32'h0040_000C, 32'h0040_0010, 32'hA5E5_000C, 1, 4, 0, 0);
        vecs[5]  = mk(0,0,0,0, 32'h0,        0, 32'h0040_0010, 32'h0040_000C, 32'h0040_0010, 32'hA5E5_000C, 1, 4, 1, 0);
        vecs[6]  = mk(0,0,0,0, 32'h0,        0, 32'h0040_0010, 32'h0040_000C, 32'h0040_0010, 32'hA5E5_000C, 1, 4, 2, 0);
        vecs[7]  = mk(0,0,0,0, 32'h0,        0, 32'h0040_0010, 32'h0040_000C, 32'h0040_0010, 32'hA5E5_000C, 1, 4, 3, 0);
        // Branch during a stall is ignored.
        vecs[8]  = mk(0,0,0,1, 32'h1234_5678, 0, 32'h0040_0010, 32'h0040_000C, 32'h0040_0010, 32'hA5E5_000C, 1, 4, 4, 0);
        vecs[9]  = mk(1,1,1,0, 32'h0,        0, 32'h0040_0014, 32'h0040_0010, 32'h0040_0014, 32'hA5E5_0010, 1, 5, 4, 0);
        // Taken branch to a misaligned target: aligned down, slot flushed.
        vecs[10] = mk(1,1,1,1, 32'h0040_0102, 0, 32'h0040_0100, 32'h0040_0014, 32'h0040_0018, 32'h0000_0013, 0, 5, 4, 1);
        vecs[11] = mk(1,1,1,0, 32'h0,        0, 32'h0040_0104, 32'h0040_0100, 32'h0040_0104, 32'hA5E5_0100, 1, 6, 4, 1);
        vecs[12] = mk(1,1,1,1, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFC, 32'h0040_0104, 32'h0040_0108, 32'h0000_0013, 0, 6, 4, 2);
        // PC wraps to zero; PCplus4 of the top word wraps too.
        vecs[13] = mk(1,1,1,0, 32'h0,        0, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000, 32'h5A5A_FFFC, 1, 7, 4, 2);
        // Clear beats the same-cycle fetch increment.
        vecs[14] = mk(1,1,1,0, 32'h0,        1, 32'h0000_0004, 32'h0000_0000, 32'h0000_0004, 32'hA5A5_0000, 1, 0, 0, 0);
        // Instruction side disabled: inst kept, no fetch count.
        vecs[15] = mk(1,1,0,0, 32'h0,        0, 32'h0000_0008, 32'h0000_0004, 32'h0000_0008, 32'hA5A5_0000, 1, 0, 0, 0);
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0; pc_en = 0; ifpc_en = 0; ifinst_en = 0; br = 0; tgt = '0; clr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr",  imem_addr, 32'h0040_0000);
        chk("rst_ifpc",  if_pc, 32'h0);
        chk("rst_inst",  if_inst, 32'h13);
        chk("rst_valid", 32'(if_v), 32'h0);
        chk("rst_state", 32'(dbg_state), 32'(BOOT));
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive_cycle(vecs[i].pe, vecs[i].ppe, vecs[i].ie, vecs[i].b, vecs[i].t, vecs[i].c);
            chk($sformatf("vec%0d_addr", i),  imem_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d_ifpc", i),  if_pc, vecs[i].e_pc);
            chk($sformatf("vec%0d_ifp4", i),  if_p4, vecs[i].e_p4);
            chk($sformatf("vec%0d_inst", i),  if_inst, vecs[i].e_inst);
            chk($sformatf("vec%0d_valid", i), 32'(if_v), 32'(vecs[i].e_v));
            chk($sformatf("vec%0d_fcnt", i),  32'(f_cnt), 32'(vecs[i].e_f));
            chk($sformatf("vec%0d_scnt", i),  32'(s_cnt), 32'(vecs[i].e_s));
            chk($sformatf("vec%0d_flcnt", i), 32'(fl_cnt), 32'(vecs[i].e_fl));
            if (i == 0) chk("boot_to_run", 32'(dbg_state), 32'(RUN));
        end

        // fetch_cnt wrap: clear, then 2^CW-1 fetches, then one more.
        drive_cycle(0, 0, 0, 0, 32'h0, 1);
        for (int i = 0; i < (1 << CW) - 1; i++) drive_cycle(1, 1, 1, 0, 32'h0, 0);
        chk("fcnt_max", 32'(f_cnt), 32'h0000_00FF);
        drive_cycle(1, 1, 1, 0, 32'h0, 0);
        chk("fcnt_wrap", 32'(f_cnt), 32'h0);
        check_model("wrap");

        // Reset asserted in the middle of a stall cycle.
        drive_cycle(0, 0, 0, 0, 32'h0, 0);
        pc_en = 0; br = 1; tgt = 32'h0000_1000;
        #3;
        rst_n = 1'b0;
        #1;
        chk("mrst_addr",  imem_addr, 32'h0040_0000);
        chk("mrst_ifpc",  if_pc, 32'h0);
        chk("mrst_ifp4",  if_p4, 32'h0);
        chk("mrst_inst",  if_inst, 32'h13);
        chk("mrst_valid", 32'(if_v), 32'h0);
        chk("mrst_cnts",  32'({f_cnt, s_cnt, fl_cnt}), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_cycle(1, 1, 1, 0, 32'h0, 0);
        chk("mrst_boot_addr",  imem_addr, 32'h0040_0000);
        chk("mrst_boot_valid", 32'(if_v), 32'h0);
        drive_cycle(1, 1, 1, 0, 32'h0, 0);
        chk("mrst_first_pc",   if_pc, 32'h0040_0000);
        chk("mrst_first_v",    32'(if_v), 32'h1);
        check_model("mrst");

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0,
                        $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                        $urandom(), $urandom_range(0, 29) == 0);
            check_model($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of the ID-stage hazard detector.
- Owns the PC register, the next-PC selection and the IF/ID pipeline register.
- Obeys the stall enables produced in ID (PC_enable, IF_ID_PCenable, IF_ID_INSTenable) and flushes IF/ID on a taken branch resolved in ID.
- Keeps wrap-around fetch/stall/flush performance counters.

Parameters:
XLEN, 32, datapath/address width
RESET_ADDR, 32'h0040_0000, PC value loaded at reset
NOP_INST, 32'h0000_0013, encoding inserted on flush/boot (addi x0,x0,0)
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
PC_enable  in  1  from hazard detector; 0 = hold PC (stall)
IF_ID_PCenable  in  1  load enable for IF_ID_PC / IF_ID_PCplus4
IF_ID_INSTenable  in  1  load enable for IF_ID_INST / IF_ID_valid
branch_taken  in  1  from ID: BEQ/jump resolved taken this cycle
branch_target  in  XLEN  from ID: redirect address
imem_addr  out  XLEN  instruction memory address (= current PC)
imem_rdata  in  XLEN  instruction word, asynchronous read of imem_addr
IF_ID_PC  out  XLEN  PC of the instruction held in IF/ID
IF_ID_PCplus4  out  XLEN  IF_ID_PC + 4
IF_ID_INST  out  XLEN  instruction held in IF/ID
IF_ID_valid  out  1  1 = IF_ID_INST is a real fetched instruction
cnt_clear  in  1  synchronous clear of all counters
fetch_cnt  out  CNT_W  instructions accepted into IF/ID
stall_cnt  out  CNT_W  cycles with PC_enable=0 in RUN
flush_cnt  out  CNT_W  taken-branch flushes

Behaviour:
- Reset (rst_n=0, asynchronous): pc=RESET_ADDR; IF_ID_PC=0; IF_ID_PCplus4=0; IF_ID_INST=NOP_INST; IF_ID_valid=0; all counters 0; FSM=BOOT.
- imem_addr = pc, combinational, at all times.
- FSM states: BOOT, RUN.
- BOOT lasts exactly one cycle after reset release. The PC is held and IF/ID is loaded with NOP_INST, valid=0. No counter increments. Next state is RUN.
- RUN applies the first matching rule each cycle:
  1) PC_enable=0: pc holds; branch_taken is ignored because ID operands are not ready during a hazard bubble. IF/ID fields load only if their own enable is 1. stall_cnt+1.
  2) PC_enable=1 and branch_taken=1: pc <= {branch_target[XLEN-1:2],2'b00}. IF/ID becomes IF_ID_INST=NOP_INST, valid=0, regardless of IF_ID_INSTenable. IF_ID_PC/PCplus4 load per IF_ID_PCenable. flush_cnt+1.
  3) PC_enable=1, no branch: pc <= pc+4. IF_ID_PC <= pc and IF_ID_PCplus4 <= pc+4 if IF_ID_PCenable. IF_ID_INST <= imem_rdata and valid <= 1 if IF_ID_INSTenable. fetch_cnt+1 only when IF_ID_INSTenable=1.
- Latency: an instruction at PC appears in IF/ID one cycle after PC is presented. A taken branch costs one flushed slot.
- Arithmetic: pc+4 and the counters wrap modulo 2^XLEN / 2^CNT_W with no saturation.
- cnt_clear=1 zeroes all counters next edge and has priority over a same-cycle increment. It does not affect pc or IF/ID.
- Reset asserted mid-operation returns to BOOT immediately. An in-flight flush or stall is discarded.

Decomposition:
- Shared package rv_pipe_pkg: XLEN, RESET_ADDR, NOP_INST, the fetch FSM state enum {BOOT,RUN}, and the IF/ID bundle struct {pc, pcplus4, inst, valid}.
- One natural sub-module: perf_counter (CNT_W-bit, inc/clear, wrap). Instantiated three times.

Test Plan:
- Reset release, PC_enable=1 throughout, imem returns addr^32'hA5A5_0000 → cycle1: IF_ID_INST=NOP, valid=0, imem_addr=0x0040_0000. Following cycles: IF_ID_PC=0x0040_0000, 0x0040_0004, ... each with valid=1; fetch_cnt increments by 1 per cycle.
- PC_enable=0 for 3 cycles at pc=0x0040_0010 with both IF_ID enables=0 → pc and IF/ID frozen; stall_cnt +3. The next fetch is 0x0040_0010.
- branch_taken=1, branch_target=0x0040_0102, PC_enable=1 → next pc=0x0040_0100; IF_ID_INST=NOP_INST, valid=0; flush_cnt=1.
- branch_taken=1 while PC_enable=0 → branch is ignored, pc holds, flush_cnt unchanged, stall_cnt +1.
- pc forced near 0xFFFF_FFFC via branch, then one normal fetch → pc wraps to 0x0000_0000 and IF_ID_PCplus4=0x0000_0000. Separately, preload fetch_cnt at 2^CNT_W−1 → wraps to 0. cnt_clear with a same-cycle fetch → fetch_cnt=0.
- rst_n pulsed low mid-stall → all outputs at reset values asynchronously; one BOOT cycle, then fetch resumes at 0x0040_0000.
